// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency 128-bit cacheline memory behind the cache.
// Optional range check is enabled by defining PMEM_RANGE_CHECK_EN.
//
// Parameters:
//   LATENCY     cycles from acceptance to the pmem_resp cycle (1..15)
//   INDEX_BITS  log2 of the line count; index = pmem_address[INDEX_BITS+3:4]
// Ports:
//   clk           rising-edge clock
//   reset_n       synchronous active-low reset (line array is not cleared)
//   pmem_read     line read request, held until pmem_resp
//   pmem_write    line write request, held until pmem_resp
//   pmem_address  byte address, bits [3:0] ignored
//   pmem_wdata    write line data
//   pmem_rdata    read line, valid in a read's resp cycle, held afterwards
//   pmem_error    (PMEM_RANGE_CHECK_EN only) out-of-range flag with pmem_resp
//   pmem_resp     single-cycle completion pulse
module pmem_responder #(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
`ifdef PMEM_RANGE_CHECK_EN
  output logic         pmem_error,
`endif
  output logic         pmem_resp
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  op_wr;
  logic                  bad;
  logic [INDEX_BITS-1:0] idx;
  logic [127:0]          wdata;
  logic [127:0]          mem [LINES];

  logic                  accept;
  logic                  enter_resp;
  logic                  src_wr;
  logic                  src_bad;
  logic [INDEX_BITS-1:0] src_idx;
  logic [INDEX_BITS-1:0] addr_idx;
  logic                  addr_bad;
  logic                  unused_addr;

  assign addr_idx = pmem_address[INDEX_BITS+3:4];

  // Offset bits and (by default) alias bits are otherwise unread.
  assign unused_addr = ^pmem_address;

`ifdef PMEM_RANGE_CHECK_EN
  assign addr_bad = (pmem_address >> (INDEX_BITS + 4)) != 16'd0;
  assign pmem_error = (state == RESP) && bad;
`else
  assign addr_bad = 1'b0;
`endif

  assign pmem_resp = (state == RESP);
  assign accept = (state == IDLE) && (pmem_read || pmem_write);

  // RESP is entered straight from IDLE when LATENCY is 1,
  // otherwise on the last BUSY cycle; rdata is loaded on that edge.
  assign enter_resp = (accept && (LATENCY == 1))
                   || ((state == BUSY) && (cnt == 4'd1));

  // In IDLE the live inputs are the request; later the latched copy.
  assign src_wr  = (state == IDLE) ? pmem_write : op_wr;
  assign src_bad = (state == IDLE) ? addr_bad : bad;
  assign src_idx = (state == IDLE) ? addr_idx : idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pmem_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= CNT_INIT;
            state <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // Simultaneous read+write counts as a write: rdata untouched.
      if (enter_resp && !src_wr) begin
        pmem_rdata <= src_bad ? '0 : mem[src_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr <= pmem_write;
      bad   <= addr_bad;
      idx   <= addr_idx;
      wdata <= pmem_wdata;
    end
  end

  // Commit on the edge leaving RESP; a reset on that edge drops it.
  always_ff @(posedge clk) begin
    if (reset_n && (state == RESP) && op_wr && !bad) begin
      mem[idx] <= wdata;
    end
  end

endmodule
